arb_encoder_4: RTL and testbench
================================

ARB_ENCODER_4 -- requirements
Module: arb_encoder_4

Interface
REQ-001 Parameter RR, default 1, priority mode: 1 = round-robin, 0 = fixed priority (req[0] highest, req[3] lowest).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  request lines, one bit per source, any combination may be set.
REQ-005 en  input  1  arbitration enable; new grant issued only while high.
REQ-006 ack  input  1  consumer accepts current grant; sampled only while grant_valid=1.
REQ-007 grant_valid  output  1  registered; grant_idx/grant_onehot are meaningful.
REQ-008 grant_idx  output  2  registered binary index of granted source.
REQ-009 grant_onehot  output  4  registered one-hot form of grant_idx; 4'b0000 when grant_valid=0.
REQ-010 busy  output  1  registered; high while in GRANT state.

Function
REQ-011 Two-state FSM shall be used: IDLE, GRANT.
- IDLE -> GRANT when en=1 and req!=0.
- GRANT -> IDLE when ack=1.
- All other cases hold state.
REQ-012 On the IDLE->GRANT edge, the block shall register the selected index; grant_valid, grant_idx, grant_onehot and busy shall update at that same edge, giving 1-cycle latency from sampled req to grant_valid.
REQ-013 Round-robin selection (RR=1) shall pick the first set req bit searching ptr, ptr+1, ptr+2, ptr+3, modulo 4.
REQ-014 ptr shall be 2 bits, reset to 0, and shall load (grant_idx+1) mod 4 on the GRANT->IDLE edge; 3 wraps to 0.
REQ-015 With RR=0, selection shall be the lowest-numbered set req bit, and ptr shall be ignored.
REQ-016 In GRANT, grant_idx/grant_onehot shall hold constant until ack, even if req changes or the granted bit drops.
REQ-017 en=0 in GRANT shall have no effect; ack is still honoured.
REQ-018 ack while in IDLE shall be ignored with no state, ptr, or output change.
REQ-019 On ack in GRANT, grant_valid, busy, and grant_onehot shall go low at the next edge; grant_idx shall retain the last value.
REQ-020 No back-to-back grant: at least one IDLE cycle shall separate consecutive grants (grant_valid low for >=1 cycle).
REQ-021 grant_onehot shall always equal (1 << grant_idx) when grant_valid=1; exactly one bit set.
REQ-022 req=4'b0000 in IDLE with en=1 shall leave the FSM in IDLE with outputs unchanged.

Reset
REQ-023 rst=1 at a clock edge shall force IDLE, ptr=0, grant_valid=0, busy=0, grant_idx=2'b00, grant_onehot=4'b0000, regardless of state or inputs.
REQ-024 Reset asserted mid-grant shall drop the grant without requiring ack; ptr shall not advance.
REQ-025 rst shall take priority over en, req, and ack in the same cycle.

Verification
REQ-026 Reset, then en=1, req=4'b1010 (RR=1) -> next cycle grant_valid=1, grant_idx=1, grant_onehot=4'b0010, busy=1.
REQ-027 Continue: ack=1 for one cycle with req held at 4'b1010 -> IDLE one cycle, then grant_idx=3; after ack, the next grant with req=4'b1111 shows grant_idx=0 (wrap).
REQ-028 RR=0, req=4'b1110 repeated with acks -> every grant is grant_idx=1.
REQ-029 In GRANT idx=2, drop req to 4'b0001 and set en=0 for 5 cycles, no ack -> grant_idx stays 2, grant_valid stays 1.
REQ-030 In GRANT idx=3, assert rst -> next cycle all outputs are zero; then req=4'b1000, en=1 -> grant_idx=3 (ptr=0, search 0..3).
REQ-031 ack pulses while IDLE with req=0 -> no output change; random req/en/ack run -> REQ-021 and REQ-020 hold every cycle.

Source files
------------

// File: rtl/arb_encoder_4.sv
// Four-source request arbiter with registered index/one-hot grant.
// Round-robin (RR=1) or fixed lowest-index-first priority (RR=0).
module arb_encoder_4 #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       en,
  input  logic       ack,
  output logic       grant_valid,
  output logic [1:0] grant_idx,
  output logic [3:0] grant_onehot,
  output logic       busy
);

  // Handshake: a grant is offered while grant_valid=1 and is retired on the
  // first edge where ack=1; ack is ignored whenever grant_valid=0.

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] onehot_q, onehot_d;
  logic [1:0] start;
  logic [1:0] cand;
  logic [1:0] sel;

  // Search from start upward (mod 4); iterating downward lets the nearest hit win.
  always_comb begin
    start = RR ? ptr_q : 2'd0;
    sel   = start;
    cand  = start;
    for (int k = 3; k >= 0; k--) begin
      cand = start + 2'(k);
      if (req[cand]) sel = cand;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (en && (req != 4'b0000)) begin
          state_d  = GRANT;
          idx_d    = sel;
          onehot_d = 4'b0001 << sel;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d  = IDLE;
          onehot_d = 4'b0000;
          ptr_d    = idx_q + 2'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        onehot_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      idx_q    <= 2'd0;
      onehot_q <= 4'b0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign busy         = (state_q == GRANT);
  assign grant_idx    = idx_q;
  assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_arb_encoder_4.sv
// Bench for arb_encoder_4: one RR=1 and one RR=0 instance on shared inputs,
// checked every cycle against a transaction-level model plus literal pins.
module tb_arb_encoder_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       en;
  logic       ack;

  logic       v0, v1, b0, b1;
  logic [1:0] i0, i1;
  logic [3:0] o0, o1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // model state, index 0 = fixed priority, index 1 = round-robin
  int m_valid[2];
  int m_idx[2];
  int m_ptr[2];

  // history for the no-back-to-back and hold checks
  logic       prev_v[2];
  logic [1:0] prev_i[2];
  logic       prev_ack;
  logic       prev_rst;

  arb_encoder_4 #(.RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .en(en), .ack(ack),
    .grant_valid(v1), .grant_idx(i1), .grant_onehot(o1), .busy(b1)
  );

  arb_encoder_4 #(.RR(1'b0)) dut_fix (
    .clk(clk), .rst(rst), .req(req), .en(en), .ack(ack),
    .grant_valid(v0), .grant_idx(i0), .grant_onehot(o0), .busy(b0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  // model: advances on the same edge the DUT samples
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0;
        m_idx[m]   = 0;
        m_ptr[m]   = 0;
      end else if (m_valid[m] == 0) begin
        if (en && req != 4'b0000) begin
          m_idx[m]   = pick(req, (m == 1) ? m_ptr[m] : 0);
          m_valid[m] = 1;
        end
      end else if (ack) begin
        m_valid[m] = 0;
        m_ptr[m]   = (m_idx[m] + 1) % 4;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic       dv[2];
    logic       db[2];
    logic [1:0] di[2];
    logic [3:0] dh[2];
    dv[0] = v0; dv[1] = v1;
    db[0] = b0; db[1] = b1;
    di[0] = i0; di[1] = i1;
    dh[0] = o0; dh[1] = o1;
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check(m ? "rr_valid" : "fix_valid", int'(dv[m]), m_valid[m]);
        check(m ? "rr_busy" : "fix_busy", int'(db[m]), m_valid[m]);
        check(m ? "rr_idx" : "fix_idx", int'(di[m]), m_idx[m]);
        check(m ? "rr_onehot" : "fix_onehot", int'(dh[m]),
              m_valid[m] ? (1 << m_idx[m]) : 0);
        if (dv[m]) begin
          check(m ? "rr_onehot_bits" : "fix_onehot_bits", $countones(dh[m]), 1);
          check(m ? "rr_onehot_form" : "fix_onehot_form", int'(dh[m]), 1 << di[m]);
        end
        if (prev_v[m] && prev_ack && !prev_rst)
          check(m ? "rr_idle_gap" : "fix_idle_gap", int'(dv[m]), 0);
        if (prev_v[m] && dv[m])
          check(m ? "rr_hold_idx" : "fix_hold_idx", int'(di[m]), int'(prev_i[m]));
      end
    end
    for (int m = 0; m < 2; m++) begin
      prev_v[m] = dv[m];
      prev_i[m] = di[m];
    end
    prev_ack = ack;
    prev_rst = rst;
  end

  // driver tasks
  task automatic drive(input logic [3:0] r, input logic e, input logic a);
    req = r;
    en  = e;
    ack = a;
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    prev_i[0] = 2'd0; prev_i[1] = 2'd0;
    prev_ack = 1'b0;  prev_rst = 1'b1;
    cycle(2);
    chk_en = 1;
    rst = 1'b0;
    check("reset_valid", int'(v1), 0);
    check("reset_onehot", int'(o1), 0);
    check("reset_idx", int'(i1), 0);

    // first grant, RR from ptr 0
    drive(4'b1010, 1'b1, 1'b0);
    cycle(1);
    check("first_valid", int'(v1), 1);
    check("first_idx", int'(i1), 1);
    check("first_onehot", int'(o1), 4'b0010);
    check("first_busy", int'(b1), 1);

    // ack, idle cycle with idx retained, then rotated grant
    drive(4'b1010, 1'b1, 1'b1);
    cycle(1);
    check("ack_valid", int'(v1), 0);
    check("ack_idx_kept", int'(i1), 1);
    check("ack_onehot", int'(o1), 0);
    drive(4'b1010, 1'b1, 1'b0);
    cycle(1);
    check("rr_next_idx", int'(i1), 3);
    check("fix_next_idx", int'(i0), 1);
    drive(4'b1010, 1'b1, 1'b1);
    cycle(1);
    drive(4'b1111, 1'b1, 1'b0);
    cycle(1);
    check("rr_wrap_idx", int'(i1), 0);
    drive(4'b1111, 1'b1, 1'b1);
    cycle(1);

    // fixed priority keeps choosing index 1; RR walks 1,2,3
    for (int n = 0; n < 3; n++) begin
      drive(4'b1110, 1'b1, 1'b0);
      cycle(1);
      check("fix_prio_idx", int'(i0), 1);
      check("rr_walk_idx", int'(i1), n + 1);
      drive(4'b1110, 1'b1, 1'b1);
      cycle(1);
    end

    // hold grant idx 2 while req drops and en is low
    drive(4'b0100, 1'b1, 1'b0);
    cycle(1);
    check("hold_start_idx", int'(i1), 2);
    drive(4'b0001, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      cycle(1);
      check("hold_idx", int'(i1), 2);
      check("hold_valid", int'(v1), 1);
    end
    drive(4'b0001, 1'b0, 1'b1);
    cycle(1);
    drive(4'b0000, 1'b0, 1'b0);
    cycle(1);

    // grant idx 3, reset mid-grant with competing inputs, ptr must be 0
    drive(4'b1000, 1'b1, 1'b0);
    cycle(1);
    check("pre_rst_idx", int'(i1), 3);
    rst = 1'b1;
    drive(4'b1111, 1'b1, 1'b1);
    cycle(1);
    rst = 1'b0;
    check("rst_valid", int'(v1), 0);
    check("rst_idx", int'(i1), 0);
    check("rst_onehot", int'(o1), 0);
    check("rst_busy", int'(b1), 0);
    drive(4'b1000, 1'b1, 1'b0);
    cycle(1);
    check("post_rst_idx", int'(i1), 3);
    drive(4'b0000, 1'b0, 1'b1);
    cycle(1);

    // ack pulses while idle with no requests
    for (int n = 0; n < 3; n++) begin
      drive(4'b0000, 1'b1, 1'b1);
      cycle(1);
      check("idle_ack_valid", int'(v1), 0);
      check("idle_ack_idx", int'(i1), 3);
      drive(4'b0000, 1'b1, 1'b0);
      cycle(1);
    end

    // random traffic, scoreboard checks every cycle
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0));
      cycle(1);
    end
    rst = 1'b0;
    drive(4'b0000, 1'b0, 1'b0);
    cycle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
